ysyx_2022040010_addr_router: RTL and testbench

Parametrised address decoder and one-outstanding request router between the LSU/IFU memory port and N_CH downstream targets (D-cache, uncached bus, CLINT, and so on). Decodes each request address against N_CH base/size windows, latches it, and forwards it to exactly one channel. It then captures that channel's response and returns it upstream. Unmapped addresses and silent channels complete with an error response instead of hanging the pipeline.

---
 rtl/ysyx_2022040010_addr_router.sv | 175 +++++++++++++++++
 tb/tb_ysyx_2022040010_addr_router.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_addr_router.sv
// Address decoder and single-outstanding request router: one upstream memory port
// fanned out to N_CH base/size windows, with error completion for holes and silent targets.
module ysyx_2022040010_addr_router #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int N_CH = 2,
  parameter logic [N_CH*ADDR_W-1:0] REG_BASE = {64'h0000_0000_A000_0000, 64'h0000_0000_8000_0000},
  parameter logic [N_CH*ADDR_W-1:0] REG_SIZE = {64'h0000_0000_1000_0000, 64'h0000_0000_0800_0000},
  parameter int TIMEOUT = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic                     req_wen,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/8-1:0]      req_wmask,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [N_CH-1:0]          ch_req_valid,
  input  logic [N_CH-1:0]          ch_req_ready,
  output logic [ADDR_W-1:0]        ch_req_addr,
  output logic                     ch_req_wen,
  output logic [DATA_W-1:0]        ch_req_wdata,
  output logic [DATA_W/8-1:0]      ch_req_wmask,
  input  logic [N_CH-1:0]          ch_rsp_valid,
  input  logic [N_CH*DATA_W-1:0]   ch_rsp_rdata,
  output logic [N_CH-1:0]          ch_rsp_ready,
  output logic [N_CH-1:0]          sel,
  output logic [31:0]              fault_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CREQ, S_CRSP, S_DONE} state_t;

  state_t               r_state;
  logic [N_CH-1:0]      r_sel;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_wen;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W/8-1:0]  r_wmask;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_err;
  logic [31:0]          r_fault;
  logic [CNT_W-1:0]     r_tmo;

  logic [N_CH-1:0]      w_hitSel;
  logic [DATA_W-1:0]    w_chData;
  logic                 w_reqHs;
  logic                 w_rspHs;
  logic                 w_tmoHit;
  logic [31:0]          w_faultNext;

  // Walk windows from high to low index so the lowest matching window is the one left standing.
  always_comb begin : decode
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] size;
    logic [ADDR_W:0]   limit;
    w_hitSel = '0;
    base     = '0;
    size     = '0;
    limit    = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      base  = REG_BASE[k*ADDR_W +: ADDR_W];
      size  = REG_SIZE[k*ADDR_W +: ADDR_W];
      limit = {1'b0, base} + {1'b0, size};
      if ((size != '0) && (req_addr >= base) && ({1'b0, req_addr} < limit)) begin
        w_hitSel    = '0;
        w_hitSel[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_chData = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_sel[k]) w_chData = ch_rsp_rdata[k*DATA_W +: DATA_W];
    end
  end

  assign w_reqHs     = |(ch_req_ready & r_sel);
  assign w_rspHs     = |(ch_rsp_valid & r_sel);
  // A request handshake on the last allowed cycle pushes the counter past TIMEOUT-1, hence >=.
  assign w_tmoHit    = (r_tmo >= CNT_W'(TIMEOUT - 1));
  assign w_faultNext = (r_fault == 32'hFFFF_FFFF) ? r_fault : r_fault + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_fault <= '0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wen   <= req_wen;
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
            r_sel   <= w_hitSel;
            r_tmo   <= '0;
            if (|w_hitSel) begin
              r_state <= S_CREQ;
            end else begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_fault <= w_faultNext;
            end
          end
        end
        S_CREQ: begin
          r_tmo <= r_tmo + CNT_W'(1);
          if (w_reqHs) begin
            r_state <= S_CRSP;
          end else if (w_tmoHit) begin
            r_state <= S_DONE;
            r_sel   <= '0;
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_fault <= w_faultNext;
          end
        end
        S_CRSP: begin
          r_tmo <= r_tmo + CNT_W'(1);
          if (w_rspHs) begin
            r_state <= S_DONE;
            r_err   <= 1'b0;
            r_rdata <= w_chData;
          end else if (w_tmoHit) begin
            r_state <= S_DONE;
            r_sel   <= '0;
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_fault <= w_faultNext;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = (r_state == S_DONE);
  assign rsp_rdata    = r_rdata;
  assign rsp_err      = r_err;
  assign ch_req_valid = (r_state == S_CREQ) ? r_sel : '0;
  assign ch_rsp_ready = (r_state == S_CRSP) ? r_sel : '0;
  assign ch_req_addr  = r_addr;
  assign ch_req_wen   = r_wen;
  assign ch_req_wdata = r_wdata;
  assign ch_req_wmask = r_wmask;
  assign sel          = r_sel;
  assign fault_cnt    = r_fault;

endmodule

// File: tb/tb_ysyx_2022040010_addr_router.sv
// Bench for the address router: directed transactions against a window/latency model
// with a per-cycle compare process and a responder emulating the two channels.
module tb_ysyx_2022040010_addr_router;

  localparam int NCH = 2;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [63:0]   req_addr = '0;
  logic          req_wen = 1'b0;
  logic [63:0]   req_wdata = '0;
  logic [7:0]    req_wmask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [63:0]   rsp_rdata;
  logic          rsp_err;
  logic [1:0]    ch_req_valid;
  logic [1:0]    ch_req_ready = '0;
  logic [63:0]   ch_req_addr;
  logic          ch_req_wen;
  logic [63:0]   ch_req_wdata;
  logic [7:0]    ch_req_wmask;
  logic [1:0]    ch_rsp_valid = '0;
  logic [127:0]  ch_rsp_rdata = '0;
  logic [1:0]    ch_rsp_ready;
  logic [1:0]    sel;
  logic [31:0]   fault_cnt;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [1:0]  chan;
    logic        err;
    logic [63:0] rdata;
    int          lat;
  } txn_t;

  txn_t        expQ[$];
  txn_t        cur;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] winBase [NCH] = '{64'h8000_0000, 64'hA000_0000};
  logic [63:0] winSize [NCH] = '{64'h0800_0000, 64'h1000_0000};
  logic [63:0] chData  [NCH] = '{64'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF};
  int          cfgReqStall = 0;
  int          cfgRspStall = 0;
  bit          cfgMute = 0;
  bit          cfgLate = 0;

  ysyx_2022040010_addr_router #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_req_addr(ch_req_addr),
    .ch_req_wen(ch_req_wen), .ch_req_wdata(ch_req_wdata), .ch_req_wmask(ch_req_wmask),
    .ch_rsp_valid(ch_rsp_valid), .ch_rsp_rdata(ch_rsp_rdata), .ch_rsp_ready(ch_rsp_ready),
    .sel(sel), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic int decodeChan(input logic [63:0] a);
    for (int k = 0; k < NCH; k++) begin
      if (winSize[k] != 0 && a >= winBase[k] && (a - winBase[k]) < winSize[k]) return k;
    end
    return -1;
  endfunction

  // Expected outcome from window rules and the channel's stall profile alone.
  function automatic txn_t buildTxn(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                                    input logic [7:0] wmask, input int rq, input int rp, input bit mute);
    txn_t t;
    int   ch;
    ch      = decodeChan(addr);
    t.addr  = addr;
    t.wen   = wen;
    t.wdata = wdata;
    t.wmask = wmask;
    t.chan  = (ch < 0) ? 2'b00 : 2'(1 << ch);
    if (ch < 0) begin
      t.err = 1'b1; t.rdata = '0; t.lat = 1;
    end else if (mute || rq > TMO - 1 || rq + 1 + rp > TMO - 1) begin
      t.err = 1'b1; t.rdata = '0; t.lat = TMO + 1;
    end else begin
      t.err = 1'b0; t.rdata = chData[ch]; t.lat = rq + rp + 3;
    end
    return t;
  endfunction

  // Channel emulation: stalls ready/valid by the configured cycle counts.
  initial begin
    int reqCnt = 0;
    int rspCnt = 0;
    forever begin
      @(posedge clk); #1;
      ch_rsp_rdata = {chData[1], chData[0]};
      if (ch_req_valid != 2'b00) begin
        ch_req_ready = (reqCnt >= cfgReqStall) ? ch_req_valid : 2'b00;
        reqCnt++;
      end else begin
        ch_req_ready = 2'b00;
        reqCnt = 0;
      end
      if (cfgLate) begin
        ch_rsp_valid = 2'b11;
      end else if (ch_rsp_ready != 2'b00 && !cfgMute) begin
        ch_rsp_valid = (rspCnt >= cfgRspStall) ? ch_rsp_ready : 2'b00;
        rspCnt++;
      end else begin
        ch_rsp_valid = 2'b00;
        if (ch_rsp_ready == 2'b00) rspCnt = 0;
      end
    end
  end

  // Per-cycle comparison against the transaction model, sampled on the falling edge.
  initial begin
    int          obs = 0;
    int          acceptObs = 0;
    bit          busy = 0;
    bit          gotValid = 0;
    logic [31:0] modelFault = '0;
    forever begin
      @(negedge clk);
      obs++;
      if (rst) begin
        busy = 0;
        modelFault = '0;
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 64'd0);
        checkOutput("rst_ch_req_valid", 64'(ch_req_valid), 64'd0);
        checkOutput("rst_ch_rsp_ready", 64'(ch_rsp_ready), 64'd0);
        checkOutput("rst_sel", 64'(sel), 64'd0);
      end else if (!busy) begin
        checkOutput("idle_req_ready", 64'(req_ready), 64'd1);
        checkOutput("idle_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("idle_ch_req_valid", 64'(ch_req_valid), 64'd0);
        checkOutput("idle_ch_rsp_ready", 64'(ch_rsp_ready), 64'd0);
        checkOutput("idle_sel", 64'(sel), 64'd0);
        if (req_valid) begin
          if (expQ.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL accept: request accepted with no expectation queued");
          end else begin
            cur = expQ.pop_front();
            busy = 1; acceptObs = obs; gotValid = 0;
          end
        end
      end else begin
        checkOutput("busy_req_ready", 64'(req_ready), 64'd0);
        if (ch_req_valid != 2'b00) begin
          checkOutput("ch_req_valid", 64'(ch_req_valid), 64'(cur.chan));
          checkOutput("ch_req_addr", ch_req_addr, cur.addr);
          checkOutput("ch_req_wen", 64'(ch_req_wen), 64'(cur.wen));
          checkOutput("ch_req_wdata", ch_req_wdata, cur.wdata);
          checkOutput("ch_req_wmask", 64'(ch_req_wmask), 64'(cur.wmask));
        end
        if (ch_rsp_ready != 2'b00) checkOutput("ch_rsp_ready", 64'(ch_rsp_ready), 64'(cur.chan));
        checkOutput("single_phase", 64'((ch_req_valid != 2'b00) && (ch_rsp_ready != 2'b00)), 64'd0);
        checkOutput("busy_sel", 64'(sel), (rsp_valid && cur.err) ? 64'd0 : 64'(cur.chan));
        if (rsp_valid) begin
          if (!gotValid) begin
            gotValid = 1;
            checkOutput("latency", 64'(obs - acceptObs), 64'(cur.lat));
            if (cur.err && modelFault != 32'hFFFF_FFFF) modelFault++;
          end
          checkOutput("done_ch_rsp_ready", 64'(ch_rsp_ready), 64'd0);
          checkOutput("rsp_err", 64'(rsp_err), 64'(cur.err));
          checkOutput("rsp_rdata", rsp_rdata, cur.rdata);
          if (rsp_ready) busy = 0;
        end else if (gotValid) begin
          checkOutput("rsp_valid_hold", 64'(rsp_valid), 64'd1);
        end
      end
      checkOutput("fault_cnt", 64'(fault_cnt), 64'(modelFault));
    end
  end

  task automatic applyStimulus(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                               input logic [7:0] wmask, input int rq, input int rp, input bit mute,
                               input int hold, input bit late, output int lat, output logic [1:0] firstCh,
                               output logic [1:0] firstSel, output logic [7:0] firstMask,
                               output logic [63:0] gotData, output logic gotErr);
    cfgReqStall = rq;
    cfgRspStall = rp;
    cfgMute     = mute;
    cfgLate     = 0;
    expQ.push_back(buildTxn(addr, wen, wdata, wmask, rq, rp, mute));
    req_valid = 1'b1; req_addr = addr; req_wen = wen; req_wdata = wdata; req_wmask = wmask;
    rsp_ready = (hold == 0);
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; firstCh = '0; firstSel = '0; firstMask = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        firstCh = ch_req_valid; firstSel = sel; firstMask = ch_req_wmask;
      end
    end while (!rsp_valid && lat < 40);
    if (!rsp_valid) begin
      checks++; failures++;
      $display("[TB] FAIL rsp_wait: rsp_valid=%0d after %0d cycles, expected 1", rsp_valid, lat);
    end
    gotData = rsp_rdata;
    gotErr  = rsp_err;
    if (late) cfgLate = 1;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    cfgLate   = 0;
    rsp_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    int          n;
    logic [1:0]  fCh;
    logic [1:0]  fSel;
    logic [7:0]  fMask;
    logic [63:0] gData;
    logic        gErr;
    logic [63:0] edgeAddr [6] = '{64'h7FFF_FFFF, 64'h8000_0000, 64'h87FF_FFFF,
                                  64'h9FFF_FFFF, 64'hAFFF_FFFF, 64'hB000_0000};
    logic        edgeErr  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(64'h8000_0010, 1'b0, 64'd0, 8'h00, 0, 0, 0, 0, 0, lat, fCh, fSel, fMask, gData, gErr);
    checkOutput("read_latency", 64'(lat), 64'd3);
    checkOutput("read_first_ch_req", 64'(fCh), 64'h1);
    checkOutput("read_first_sel", 64'(fSel), 64'h1);
    checkOutput("read_data", gData, 64'hDEAD_BEEF);
    checkOutput("read_err", 64'(gErr), 64'd0);

    applyStimulus(64'h87FF_FFF8, 1'b1, 64'h1122_3344_5566_7788, 8'hF0, 0, 0, 0, 0, 0, lat, fCh, fSel, fMask, gData, gErr);
    checkOutput("top_ch0_ch_req", 64'(fCh), 64'h1);
    checkOutput("top_ch0_err", 64'(gErr), 64'd0);

    applyStimulus(64'h8800_0000, 1'b0, 64'd0, 8'hFF, 0, 0, 0, 0, 0, lat, fCh, fSel, fMask, gData, gErr);
    checkOutput("unmapped_latency", 64'(lat), 64'd1);
    checkOutput("unmapped_err", 64'(gErr), 64'd1);
    checkOutput("unmapped_data", gData, 64'd0);
    checkOutput("unmapped_fault_cnt", 64'(fault_cnt), 64'd1);

    applyStimulus(64'hA000_0000, 1'b1, 64'h0000_0000_0000_CAFE, 8'h0F, 0, 0, 0, 0, 0, lat, fCh, fSel, fMask, gData, gErr);
    checkOutput("ch1_first_ch_req", 64'(fCh), 64'h2);
    checkOutput("ch1_wmask", 64'(fMask), 64'h0F);
    checkOutput("ch1_data", gData, 64'h0123_4567_89AB_CDEF);

    applyStimulus(64'hA000_1000, 1'b0, 64'd0, 8'h00, 5, 0, 0, 3, 0, lat, fCh, fSel, fMask, gData, gErr);
    checkOutput("backpressure_latency", 64'(lat), 64'd8);
    checkOutput("backpressure_err", 64'(gErr), 64'd0);

    applyStimulus(64'h8000_0100, 1'b0, 64'd0, 8'h00, 0, 0, 1, 2, 1, lat, fCh, fSel, fMask, gData, gErr);
    checkOutput("timeout_latency", 64'(lat), 64'd9);
    checkOutput("timeout_err", 64'(gErr), 64'd1);
    checkOutput("timeout_data", gData, 64'd0);
    checkOutput("timeout_fault_cnt", 64'(fault_cnt), 64'd2);

    applyStimulus(64'h8000_0200, 1'b0, 64'd0, 8'h00, 0, 6, 0, 0, 0, lat, fCh, fSel, fMask, gData, gErr);
    checkOutput("tie_latency", 64'(lat), 64'd9);
    checkOutput("tie_err", 64'(gErr), 64'd0);
    checkOutput("tie_data", gData, 64'hDEAD_BEEF);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(edgeAddr[i], 1'b0, 64'd0, 8'h00, 0, 0, 0, 0, 0, lat, fCh, fSel, fMask, gData, gErr);
      checkOutput($sformatf("edge_err_%0d", i), 64'(gErr), 64'(edgeErr[i]));
    end
    checkOutput("edge_fault_cnt", 64'(fault_cnt), 64'd5);

    // Abort a transaction while the channel sits on its response.
    cfgReqStall = 0; cfgRspStall = 20; cfgMute = 0;
    expQ.push_back(buildTxn(64'h8000_0300, 1'b0, 64'd0, 8'h00, 0, 20, 0));
    req_valid = 1'b1; req_addr = 64'h8000_0300; req_wen = 1'b0; req_wdata = '0; req_wmask = '0;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ch_rsp_ready == 2'b00 && n < 20);
    checkOutput("pre_reset_ch_rsp_ready", 64'(ch_rsp_ready), 64'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("async_rst_ch_rsp_ready", 64'(ch_rsp_ready), 64'd0);
    checkOutput("async_rst_sel", 64'(sel), 64'd0);
    checkOutput("async_rst_fault_cnt", 64'(fault_cnt), 64'd0);
    checkOutput("async_rst_ch_req_addr", ch_req_addr, 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    cfgRspStall = 0;
    @(posedge clk); #1;

    applyStimulus(64'hA000_0040, 1'b0, 64'd0, 8'h00, 0, 0, 0, 0, 0, lat, fCh, fSel, fMask, gData, gErr);
    checkOutput("post_reset_latency", 64'(lat), 64'd3);
    checkOutput("post_reset_data", gData, 64'h0123_4567_89AB_CDEF);
    checkOutput("post_reset_err", 64'(gErr), 64'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
